// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes an instruction into ALU operands/opcode and registers it behind a valid/ready handshake.
// Optional two-entry skid variant (registered in_ready) enabled with ALU_ISSUE_SKID_EN.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_src0,
    output logic [XLEN-1:0] alu_src1,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);
    localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd2,  OP_SLT  = 5'd4,  OP_SLTU = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_XOR  = 5'd11, OP_SLL  = 5'd14;
    localparam logic [4:0] OP_SRL  = 5'd15, OP_SRA  = 5'd16, OP_SRC1 = 5'd18;

    typedef struct packed {
        logic [XLEN-1:0] src0;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] pc;
        logic [4:0]      op;
        logic [4:0]      rd;
        logic            we;
        logic            ill;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt_ext, rs2_shamt;
    logic            writes_rd;
    entry_t          dec;
    entry_t          main_reg;
    logic            out_valid_reg;
    logic            accept;

    assign opcode    = in_inst[6:0];
    assign funct3    = in_inst[14:12];
    assign funct7    = in_inst[31:25];
    assign imm_i     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s     = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_u     = {in_inst[31:12], 12'b0};
    assign shamt_ext = {{(XLEN-5){1'b0}}, in_inst[24:20]};
    assign rs2_shamt = {{(XLEN-5){1'b0}}, in_rs2_data[4:0]};

    always_comb begin
        dec       = '0;
        dec.src0  = in_rs1_data;
        dec.pc    = in_pc;
        dec.op    = OP_ADD;
        dec.rd    = in_inst[11:7];
        writes_rd = 1'b0;
        case (opcode)
            7'b0110011: begin
                writes_rd = 1'b1;
                dec.src1  = in_rs2_data;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.op = OP_ADD;
                        3'b001:  begin dec.op = OP_SLL; dec.src1 = rs2_shamt; end
                        3'b010:  dec.op = OP_SLT;
                        3'b011:  dec.op = OP_SLTU;
                        3'b100:  dec.op = OP_XOR;
                        3'b101:  begin dec.op = OP_SRL; dec.src1 = rs2_shamt; end
                        3'b110:  dec.op = OP_OR;
                        default: dec.op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec.op = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec.op   = OP_SRA;
                    dec.src1 = rs2_shamt;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            7'b0010011: begin
                writes_rd = 1'b1;
                dec.src1  = imm_i;
                case (funct3)
                    3'b000:  dec.op = OP_ADD;
                    3'b010:  dec.op = OP_SLT;
                    3'b011:  dec.op = OP_SLTU;
                    3'b100:  dec.op = OP_XOR;
                    3'b110:  dec.op = OP_OR;
                    3'b111:  dec.op = OP_AND;
                    3'b001: begin
                        dec.op   = OP_SLL;
                        dec.src1 = shamt_ext;
                        dec.ill  = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec.op   = (funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                        dec.src1 = shamt_ext;
                        dec.ill  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            7'b0110111: begin writes_rd = 1'b1; dec.op = OP_SRC1; dec.src0 = '0; dec.src1 = imm_u; end
            7'b0010111: begin writes_rd = 1'b1; dec.src0 = in_pc; dec.src1 = imm_u; end
            7'b1101111,
            7'b1100111: begin writes_rd = 1'b1; dec.src0 = in_pc; dec.src1 = XLEN'(4); end
            7'b0000011: begin writes_rd = 1'b1; dec.src1 = imm_i; end
            7'b0100011: dec.src1 = imm_s;
            default:    dec.ill = 1'b1;
        endcase
        // Illegal encodings issue as a harmless ADD of zeros that never writes back.
        if (dec.ill) begin
            dec.op    = OP_ADD;
            dec.src0  = '0;
            dec.src1  = '0;
            writes_rd = 1'b0;
        end
        dec.we = writes_rd && (dec.rd != 5'd0);
    end

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_reg;
    logic   skid_valid_reg;
    logic   main_free;

    // in_ready depends only on registered state, breaking the out_ready timing path.
    assign in_ready  = !skid_valid_reg;
    assign main_free = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_reg       <= '0;
            skid_reg       <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            if (main_free) begin
                main_reg       <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (main_free) begin
                main_reg      <= dec;
                out_valid_reg <= 1'b1;
            end else begin
                skid_reg       <= dec;
                skid_valid_reg <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            main_reg      <= '0;
        end else begin
            if (flush)          out_valid_reg <= 1'b0;
            else if (accept)    out_valid_reg <= 1'b1;
            else if (out_ready) out_valid_reg <= 1'b0;
            if (accept)         main_reg      <= dec;
        end
    end
`endif

    assign out_valid   = out_valid_reg;
    assign alu_src0    = main_reg.src0;
    assign alu_src1    = main_reg.src1;
    assign alu_op      = main_reg.op;
    assign out_pc      = main_reg.pc;
    assign out_rd      = main_reg.rd;
    assign out_we      = main_reg.we;
    assign out_illegal = main_reg.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus stall, flush and reset sequences.
// Expectations for the stall window follow ALU_ISSUE_SKID_EN when it is defined.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, in_rs1_data, in_rs2_data;
    logic [31:0] alu_src0, alu_src1, out_pc;
    logic [4:0]  alu_op, out_rd;
    logic        out_we, out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op),
        .out_pc(out_pc), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

`ifdef ALU_ISSUE_SKID_EN
    localparam int EXP_STALL_ACC = 1;
`else
    localparam int EXP_STALL_ACC = 0;
`endif

    typedef struct {
        logic [31:0] inst, pc, rs1, rs2, src0, src1;
        logic [4:0]  op, rd;
        logic        we, ill;
    } vec_t;

    vec_t        vecs[17];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic v, input logic [31:0] s0, input logic [31:0] s1,
                                           input logic [4:0] op, input logic [31:0] pc,
                                           input logic [4:0] rd, input logic we, input logic ill);
        return {19'b0, v, s0, s1, op, pc, rd, we, ill};
    endfunction

    function automatic logic [127:0] dut_out();
        return pack(out_valid, alu_src0, alu_src1, alu_op, out_pc, out_rd, out_we, out_illegal);
    endfunction

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] s0, input logic [31:0] s1,
                                input logic [4:0] op, input logic [4:0] rd, input logic we, input logic ill);
        vec_t v;
        v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.src0 = s0; v.src1 = s1;
        v.op = op; v.rd = rd; v.we = we; v.ill = ill;
        return v;
    endfunction

    // ADDI x1,x0,k: a tagged item whose src1 carries k.
    function automatic logic [31:0] addi(input int k);
        logic [31:0] r;
        logic [31:0] kv;
        kv = k;
        r = 32'h0000_0093;
        r[31:20] = kv[11:0];
        return r;
    endfunction

    initial begin
        int next_k, stall_acc, pops;
        vecs[0]  = mk(32'h002081B3, 32'h000, 32'd5,        32'd7,        32'd5,        32'd7,        5'd0,  5'd3,  1, 0);
        vecs[1]  = mk(32'h40315093, 32'h004, 32'h80000000, 32'd0,        32'h80000000, 32'd3,        5'd16, 5'd1,  1, 0);
        vecs[2]  = mk(32'h00209233, 32'h008, 32'h11,       32'h23,       32'h11,       32'd3,        5'd14, 5'd4,  1, 0);
        vecs[3]  = mk(32'h123452B7, 32'h00C, 32'hAAAA,     32'hBBBB,     32'd0,        32'h12345000, 5'd18, 5'd5,  1, 0);
        vecs[4]  = mk(32'h00001317, 32'h100, 32'd1,        32'd2,        32'h100,      32'h1000,     5'd0,  5'd6,  1, 0);
        vecs[5]  = mk(32'h0000007F, 32'h104, 32'h55,       32'h66,       32'd0,        32'd0,        5'd0,  5'd0,  0, 1);
        vecs[6]  = mk(32'h00208033, 32'h108, 32'd5,        32'd7,        32'd5,        32'd7,        5'd0,  5'd0,  0, 0);
        vecs[7]  = mk(32'h402083B3, 32'h10C, 32'd10,       32'd3,        32'd10,       32'd3,        5'd2,  5'd7,  1, 0);
        vecs[8]  = mk(32'hFFF00093, 32'h110, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 5'd0,  5'd1,  1, 0);
        vecs[9]  = mk(32'hFE20AE23, 32'h114, 32'h1000,     32'd9,        32'h1000,     32'hFFFFFFFC, 5'd0,  5'd28, 0, 0);
        vecs[10] = mk(32'h000000EF, 32'h200, 32'd3,        32'd4,        32'h200,      32'd4,        5'd0,  5'd1,  1, 0);
        vecs[11] = mk(32'h40111093, 32'h204, 32'd7,        32'd8,        32'd0,        32'd0,        5'd0,  5'd1,  0, 1);
        vecs[12] = mk(32'h022081B3, 32'h208, 32'd7,        32'd8,        32'd0,        32'd0,        5'd0,  5'd3,  0, 1);
        vecs[13] = mk(32'h0080A283, 32'h20C, 32'h100,      32'd0,        32'h100,      32'd8,        5'd0,  5'd5,  1, 0);
        vecs[14] = mk(32'h0F00C113, 32'h210, 32'h33,       32'd0,        32'h33,       32'hF0,       5'd11, 5'd2,  1, 0);
        vecs[15] = mk(32'h4020D1B3, 32'h214, 32'hF0,       32'h24,       32'hF0,       32'd4,        5'd16, 5'd3,  1, 0);
        vecs[16] = mk(32'h0020B1B3, 32'h218, 32'd1,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 5'd5,  5'd3,  1, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", dut_out(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        check("reset_in_ready", 128'(in_ready), 128'(1));

        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc;
            in_rs1_data = vecs[i].rs1; in_rs2_data = vecs[i].rs2;
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_inst_%h", i, vecs[i].inst), dut_out(),
                  pack(1, vecs[i].src0, vecs[i].src1, vecs[i].op, vecs[i].pc, vecs[i].rd, vecs[i].we, vecs[i].ill));
        end
        @(negedge clk);
        check("idle_after_table", 128'(out_valid), 128'(0));

        // Stall: out_ready low for cycles 0..3, four tagged items offered back to back.
        next_k = 1; stall_acc = 0; pops = 0;
        in_rs1_data = '0; in_pc = 32'h300;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc >= 1 && cyc <= 3)
                check($sformatf("stall_hold_c%0d", cyc), {out_valid, alu_src1}, {1'b1, 32'd1});
            out_ready = (cyc >= 4);
            in_valid  = (next_k <= 4);
            in_inst   = addi(next_k);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected actual=%h required=none", alu_src1);
                end else begin
                    check($sformatf("pop_order_%0d", pops), 128'(alu_src1), 128'(q.pop_front()));
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(next_k);
                if (cyc >= 1 && cyc <= 3) stall_acc++;
                next_k++;
            end
            if (next_k > 4 && q.size() == 0) break;
        end
        in_valid = 1'b0;
        check("stall_accepts", 128'(stall_acc), 128'(EXP_STALL_ACC));
        check("pop_count", 128'(pops), 128'(4));
        check("queue_drained", 128'(q.size()), 128'(0));

        // Flush with a held entry and a same-cycle input that would otherwise be taken.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = addi(10);
        @(negedge clk);
        check("flush_pre", {out_valid, alu_src1}, {1'b1, 32'd10});
        in_inst = addi(11); flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 128'(out_valid), 128'(0));
        check("flush_hold_src1", 128'(alu_src1), 128'(10));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("flush_drop_%0d", i), {out_valid, alu_src1}, {1'b0, 32'd10});
        end

        // Reset in the middle of a stall, with a second item pending upstream.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = addi(20); in_pc = 32'h400;
        @(negedge clk);
        in_inst = addi(21);
        @(negedge clk);
        check("rst_pre_stall", {out_valid, alu_src1}, {1'b1, 32'd20});
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_stall", dut_out(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_empty_%0d", i), 128'(out_valid), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
